// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: register map offsets, CTRL bit positions and segment constants for seven_seg_ctrl
package seven_seg_pkg;
  localparam logic [7:0] DIGIT_OFS = 8'h00;
  localparam int CTRL_EN = 0;
  localparam int CTRL_LZ = 1;
  localparam int CTRL_BRIGHT = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // active-low {g,f,e,d,c,b,a} for nibble values F down to 0
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [7:0] DOT_OFS(input int h);
    return 8'(h);
  endfunction
  function automatic logic [7:0] CTRL_OFS(input int h);
    return 8'(h + 1);
  endfunction
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: nibble plus decimal point to active-low {dp,g,f,e,d,c,b,a}
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  assign seg = {~dp, SEG_LUT[nib]};
endmodule

// File: rtl/seven_seg_ctrl.sv
// seven_seg_ctrl: bus-mapped multiplexed seven-segment controller with PWM and leading-zero blanking
// Optional register readback on BUS_DATA when SEVEN_SEG_READBACK_EN is defined.
module seven_seg_ctrl
  import seven_seg_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter logic [7:0] BASE_ADDR  = 8'hD0,
  parameter int         CLK_DIV    = 100000,
  parameter logic [7:0] CTRL_RST   = 8'hF1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [7:0]            BUS_ADDR,
  inout  wire logic [7:0]       BUS_DATA,
  input  logic                  BUS_WE,
  output logic [NUM_DIGITS-1:0] SEG_SELECT,
  output logic [7:0]            HEX_OUT
);
  localparam int H = NUM_DIGITS / 2;
  localparam int TICKS = CLK_DIV / 16;
  localparam int TW = $clog2(TICKS);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [7:0] digit_r [H];
  logic [7:0] dot_r;
  logic ctl_en, lz_en;
  logic [3:0] bright;
  logic [TW-1:0] tick;
  logic [3:0] phase;
  logic [IW-1:0] idx;
  logic [7:0] ofs, seg, nxt_hex;
  logic [NUM_DIGITS-1:0] nxt_sel, lead0;
  logic in_rng, hit_dig, hit_dot, hit_ctl, tick_wrap, lit, blank, all0;
  logic [3:0] nib [NUM_DIGITS];
  assign in_rng = BUS_ADDR >= BASE_ADDR;
  assign ofs = BUS_ADDR - BASE_ADDR;
  assign hit_dig = in_rng && ofs < DOT_OFS(H);
  assign hit_dot = in_rng && ofs == DOT_OFS(H);
  assign hit_ctl = in_rng && ofs == CTRL_OFS(H);
  assign tick_wrap = tick == TW'(TICKS - 1);
  // byte 0 holds the leftmost pair; odd digit indices sit in the high nibble
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
    assign nib[i] = (i % 2 == 1) ? digit_r[(NUM_DIGITS-1-i)/2][7:4] : digit_r[(NUM_DIGITS-1-i)/2][3:0];
  end
  always_comb begin
    lead0 = '0;
    all0 = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all0 = all0 && nib[i] == 4'h0;
      lead0[i] = all0;
    end
  end
  hex_to_seg u_dec (.nib(nib[idx]), .dp(dot_r[idx]), .seg(seg));
  assign lit = ctl_en && phase < bright;
  assign blank = lz_en && idx != '0 && lead0[idx];
  assign nxt_hex = !lit ? SEG_BLANK : blank ? (seg | 8'h7F) : seg;
  assign nxt_sel = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < H; i++) digit_r[i] <= '0;
      dot_r <= '0;
      ctl_en <= CTRL_RST[CTRL_EN];
      lz_en <= CTRL_RST[CTRL_LZ];
      bright <= CTRL_RST[CTRL_BRIGHT +: 4];
      tick <= '0;
      phase <= '0;
      idx <= IW'(NUM_DIGITS - 1);
      SEG_SELECT <= '1;
      HEX_OUT <= SEG_BLANK;
    end else begin
      for (int i = 0; i < H; i++)
        if (BUS_WE && hit_dig && ofs == DIGIT_OFS + 8'(i)) digit_r[i] <= BUS_DATA;
      if (BUS_WE && hit_dot) dot_r <= BUS_DATA;
      if (BUS_WE && hit_ctl) begin
        ctl_en <= BUS_DATA[CTRL_EN];
        lz_en <= BUS_DATA[CTRL_LZ];
        bright <= BUS_DATA[CTRL_BRIGHT +: 4];
      end
      tick <= tick_wrap ? '0 : tick + 1'b1;
      if (tick_wrap) phase <= phase + 4'd1;
      if (tick_wrap && phase == 4'hF) idx <= (idx == '0) ? IW'(NUM_DIGITS - 1) : idx - 1'b1;
      SEG_SELECT <= nxt_sel;
      HEX_OUT <= nxt_hex;
    end
`ifdef SEVEN_SEG_READBACK_EN
  logic [7:0] rd;
  always_comb begin
    rd = hit_dot ? dot_r : {bright, 2'b00, lz_en, ctl_en};
    for (int i = 0; i < H; i++) rd = (hit_dig && ofs == DIGIT_OFS + 8'(i)) ? digit_r[i] : rd;
  end
  assign BUS_DATA = (!BUS_WE && (hit_dig || hit_dot || hit_ctl)) ? rd : 8'bz;
`else
  assign BUS_DATA = 8'bz;
`endif
endmodule

// File: tb/tb_seven_seg_ctrl.sv
// tb_seven_seg_ctrl: scoreboard bench for seven_seg_ctrl against a cycle-count reference model
module tb_seven_seg_ctrl;
  localparam int N = 4;
  localparam int DIV = 32;
  localparam int H = N / 2;
  localparam logic [7:0] BASE = 8'hD0;
  typedef struct packed {logic [N-1:0] sel; logic [7:0] hex;} exp_t;
  logic CLK = 1'b0, RESET_N = 1'b1, BUS_WE = 1'b0, drv_en = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00, drv = 8'h00;
  wire [7:0] BUS_DATA;
  logic [N-1:0] SEG_SELECT;
  logic [7:0] HEX_OUT, hex8;
  logic [7:0] sel8, seen8;
  int tests = 0, fails = 0;
  logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int mdig [N];
  logic [7:0] mdot;
  logic men, mlz;
  logic [3:0] mbr;
  int cyc;
  exp_t q [$];
  assign BUS_DATA = drv_en ? drv : 8'bz;
  always #5 CLK = ~CLK;
  seven_seg_ctrl #(.NUM_DIGITS(N), .BASE_ADDR(BASE), .CLK_DIV(DIV), .CTRL_RST(8'hF1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUS_WE(BUS_WE), .SEG_SELECT(SEG_SELECT), .HEX_OUT(HEX_OUT));
  seven_seg_ctrl #(.NUM_DIGITS(8), .BASE_ADDR(8'h40), .CLK_DIV(DIV), .CTRL_RST(8'hF1)) u8 (
    .CLK(CLK), .RESET_N(RESET_N), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUS_WE(BUS_WE), .SEG_SELECT(sel8), .HEX_OUT(hex8));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < N; i++) mdig[i] = 0;
    mdot = 8'h00;
    men = 1'b1;
    mlz = 1'b0;
    mbr = 4'hF;
    cyc = 0;
    q.delete();
  endtask
  task automatic mwrite(input logic [7:0] a, input logic [7:0] d);
    if (a >= BASE && a < BASE + 8'(H)) begin
      mdig[N-1-2*int'(a-BASE)] = int'(d[7:4]);
      mdig[N-2-2*int'(a-BASE)] = int'(d[3:0]);
    end else if (a == BASE + 8'(H)) mdot = d;
    else if (a == BASE + 8'(H+1)) begin
      men = d[0];
      mlz = d[1];
      mbr = d[7:4];
    end
  endtask
  // output at cycle count c: digit from slot number, phase from position within the slot
  function automatic exp_t model(input int c);
    exp_t e;
    int d, ph;
    bit on, bl;
    d = N - 1 - (c / DIV) % N;
    ph = (c % DIV) / (DIV / 16);
    on = men && ph < int'(mbr);
    bl = mlz && d != 0;
    for (int j = d; j < N; j++) if (mdig[j] != 0) bl = 0;
    e.sel = on ? ~(N'(1) << d) : '1;
    e.hex = on ? ((bl ? 8'hFF : lut[mdig[d]]) & (mdot[d] ? 8'h7F : 8'hFF)) : 8'hFF;
    return e;
  endfunction
  always @(posedge CLK)
    if (RESET_N) begin
      q.push_back(model(cyc));
      if (BUS_WE) mwrite(BUS_ADDR, BUS_DATA);
      cyc++;
    end
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET_N) begin
      q.delete();
      chk("rst_sel", 32'(SEG_SELECT), 32'({N{1'b1}}));
      chk("rst_hex", 32'(HEX_OUT), 32'hFF);
    end else if (q.size() == 0) begin
      chk("queue_empty", 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      chk("sel", 32'(SEG_SELECT), 32'(e.sel));
      chk("hex", 32'(HEX_OUT), 32'(e.hex));
    end
  end
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    #1;
    BUS_ADDR = a;
    drv = d;
    drv_en = 1'b1;
    BUS_WE = 1'b1;
    @(negedge CLK);
    #1;
    BUS_WE = 1'b0;
    drv_en = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic release_rst();
    @(negedge CLK);
    #1;
    mreset();
    RESET_N = 1'b1;
  endtask
  initial begin
    mreset();
    #1 RESET_N = 1'b0;
    idle(3);
    release_rst();
`ifdef SEVEN_SEG_READBACK_EN
    BUS_ADDR = 8'hD0;
    #1 chk("rd_d0_rst", 32'(BUS_DATA), 32'h00);
    BUS_ADDR = 8'hD3;
    #1 chk("rd_ctrl_rst", 32'(BUS_DATA), 32'hF1);
`endif
    idle(300);
    wr(8'hD0, 8'h12);
    wr(8'hD1, 8'h3A);
    idle(140);
    wr(8'hD3, 8'h41);
    idle(140);
    wr(8'hD3, 8'h01);
    idle(140);
    wr(8'hD0, 8'h00);
    wr(8'hD1, 8'h05);
    wr(8'hD3, 8'hF3);
    idle(140);
    wr(8'hD2, 8'h04);
    idle(140);
    for (int i = 0; i < 40; i++) begin
      wr(8'hCE + 8'($urandom_range(0, 7)), 8'($urandom));
      idle($urandom_range(0, 40));
    end
    wr(8'hD0, 8'h9C);
    wr(8'hD3, 8'hF1);
    idle(50);
    @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    mreset();
    #1;
    chk("async_sel", 32'(SEG_SELECT), 32'({N{1'b1}}));
    chk("async_hex", 32'(HEX_OUT), 32'hFF);
    idle(4);
    release_rst();
    idle(300);
    wr(8'hD4, 8'h77);
    wr(8'hCF, 8'h55);
    idle(140);
`ifdef SEVEN_SEG_READBACK_EN
    wr(8'hD1, 8'hA5);
    BUS_ADDR = 8'hD1;
    #1 chk("rd_d1", 32'(BUS_DATA), 32'hA5);
    idle(2);
`endif
    seen8 = 8'h00;
    for (int i = 0; i < 8 * DIV; i++) begin
      @(negedge CLK);
      if (sel8 != 8'hFF) begin
        chk("n8_onehot", 32'($countones(~sel8)), 32'd1);
        seen8 = seen8 | ~sel8;
      end
    end
    chk("n8_anodes", 32'($countones(seen8)), 32'd8);
    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
